// File: rtl/rs_pkg.sv
// Shared constants and entry layout for the reservation station.
// TAG_NONE marks an operand whose value is already present.
package rs_pkg;

  localparam int TAG_NONE   = 0;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_CDB    = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 4;
  localparam int DEF_OP_W   = 6;

  typedef struct packed {
    logic                  busy;
    logic [DEF_OP_W-1:0]   op;
    logic [DEF_TAG_W-1:0]  dest;
    logic [DEF_DATA_W-1:0] vj;
    logic [DEF_DATA_W-1:0] vk;
    logic [DEF_TAG_W-1:0]  qj;
    logic [DEF_TAG_W-1:0]  qk;
  } rs_entry_t;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit priority encoder.
// Ports: req vector in; idx of lowest set bit and any-set flag out.
module rs_prio_enc #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_station.sv
// Reservation station: dispatch, CDB wakeup/bypass, in-order select.
// Ports: dispatch bundle, CDB channels, issue bundle, count/flags.
module rs_station
  import rs_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int CDB_PORTS = DEF_CDB,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int OP_W      = DEF_OP_W
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush_in,
  input  logic                        disp_valid_in,
  output logic                        disp_ready_out,
  input  logic [OP_W-1:0]             disp_op_in,
  input  logic [TAG_W-1:0]            disp_dest_in,
  input  logic [DATA_W-1:0]           disp_vj_in,
  input  logic [DATA_W-1:0]           disp_vk_in,
  input  logic [TAG_W-1:0]            disp_qj_in,
  input  logic [TAG_W-1:0]            disp_qk_in,
  input  logic [CDB_PORTS-1:0]        cdb_valid_in,
  input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag_in,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_val_in,
  output logic                        iss_valid_out,
  input  logic                        iss_ready_in,
  output logic [OP_W-1:0]             iss_op_out,
  output logic [TAG_W-1:0]            iss_dest_out,
  output logic [DATA_W-1:0]           iss_vj_out,
  output logic [DATA_W-1:0]           iss_vk_out,
  output logic [$clog2(DEPTH):0]      count_out,
  output logic                        almost_full_out
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [TAG_W-1:0] NONE = TAG_W'(TAG_NONE);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
  } slot_t;

  slot_t             ent [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DEPTH-1:0]  rdy_vec;
  logic [CW-1:0]     count;
  logic [IW-1:0]     free_idx;
  logic [IW-1:0]     sel_idx;
  logic              any_free;
  logic              any_rdy;
  logic              disp_fire;
  logic              iss_fire;

  // {hit, value}; hit means a CDB channel carries tag q
  logic [DATA_W:0]   wj [DEPTH];
  logic [DATA_W:0]   wk [DEPTH];
  logic [DATA_W:0]   dj;
  logic [DATA_W:0]   dk;

  // Descending scan so the lowest channel index wins.
  function automatic logic [DATA_W:0] snoop(
    input logic [TAG_W-1:0]            q,
    input logic [CDB_PORTS-1:0]        v,
    input logic [CDB_PORTS*TAG_W-1:0]  t,
    input logic [CDB_PORTS*DATA_W-1:0] d
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int c = CDB_PORTS - 1; c >= 0; c--) begin
      if (q != NONE && v[c] && t[c*TAG_W +: TAG_W] == q)
        r = {1'b1, d[c*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wj[i] = snoop(ent[i].qj, cdb_valid_in,
                    cdb_tag_in, cdb_val_in);
      wk[i] = snoop(ent[i].qk, cdb_valid_in,
                    cdb_tag_in, cdb_val_in);
      rdy_vec[i] = busy[i] && ent[i].qj == NONE
                   && ent[i].qk == NONE;
    end
    dj = snoop(disp_qj_in, cdb_valid_in,
               cdb_tag_in, cdb_val_in);
    dk = snoop(disp_qk_in, cdb_valid_in,
               cdb_tag_in, cdb_val_in);
  end

  rs_prio_enc #(.N(DEPTH)) u_vac (
    .req (~busy),
    .idx (free_idx),
    .any (any_free)
  );

  rs_prio_enc #(.N(DEPTH)) u_sel (
    .req (rdy_vec),
    .idx (sel_idx),
    .any (any_rdy)
  );

  assign disp_ready_out  = any_free;
  assign iss_valid_out   = any_rdy && !flush_in;
  assign disp_fire       = disp_valid_in && disp_ready_out
                           && rdy_in && !flush_in;
  assign iss_fire        = iss_valid_out && iss_ready_in && rdy_in;
  assign count_out       = count;
  assign almost_full_out = count == CW'(DEPTH - 1);

  assign iss_op_out   = ent[sel_idx].op;
  assign iss_dest_out = ent[sel_idx].dest;
  assign iss_vj_out   = ent[sel_idx].vj;
  assign iss_vk_out   = ent[sel_idx].vk;

  // Vacancy comes from pre-edge busy, so a slot freed by issue
  // this cycle is never the one being written.
  always_comb begin
    busy_nxt = busy;
    if (iss_fire)
      busy_nxt[sel_idx] = 1'b0;
    if (disp_fire)
      busy_nxt[free_idx] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        busy  <= '0;
        count <= '0;
      end else begin
        busy  <= busy_nxt;
        count <= count + CW'(disp_fire) - CW'(iss_fire);
      end
    end
  end

  // Payload is don't-care while not busy, so it is not reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (disp_fire && free_idx == IW'(i)) begin
          ent[i].op   <= disp_op_in;
          ent[i].dest <= disp_dest_in;
          ent[i].vj   <= dj[DATA_W] ? dj[DATA_W-1:0] : disp_vj_in;
          ent[i].vk   <= dk[DATA_W] ? dk[DATA_W-1:0] : disp_vk_in;
          ent[i].qj   <= dj[DATA_W] ? NONE : disp_qj_in;
          ent[i].qk   <= dk[DATA_W] ? NONE : disp_qk_in;
        end else if (busy[i]) begin
          if (wj[i][DATA_W]) begin
            ent[i].vj <= wj[i][DATA_W-1:0];
            ent[i].qj <= NONE;
          end
          if (wk[i][DATA_W]) begin
            ent[i].vk <= wk[i][DATA_W-1:0];
            ent[i].qk <= NONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station at default parameters.
// Checks reset, dispatch/issue, wakeup, bypass, full, flush, freeze.
module tb_rs_station;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        disp_valid_in;
  logic        disp_ready_out;
  logic [5:0]  disp_op_in;
  logic [3:0]  disp_dest_in;
  logic [31:0] disp_vj_in;
  logic [31:0] disp_vk_in;
  logic [3:0]  disp_qj_in;
  logic [3:0]  disp_qk_in;
  logic [1:0]  cdb_valid_in;
  logic [7:0]  cdb_tag_in;
  logic [63:0] cdb_val_in;
  logic        iss_valid_out;
  logic        iss_ready_in;
  logic [5:0]  iss_op_out;
  logic [3:0]  iss_dest_out;
  logic [31:0] iss_vj_out;
  logic [31:0] iss_vk_out;
  logic [4:0]  count_out;
  logic        almost_full_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  rs_station dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .flush_in        (flush_in),
    .disp_valid_in   (disp_valid_in),
    .disp_ready_out  (disp_ready_out),
    .disp_op_in      (disp_op_in),
    .disp_dest_in    (disp_dest_in),
    .disp_vj_in      (disp_vj_in),
    .disp_vk_in      (disp_vk_in),
    .disp_qj_in      (disp_qj_in),
    .disp_qk_in      (disp_qk_in),
    .cdb_valid_in    (cdb_valid_in),
    .cdb_tag_in      (cdb_tag_in),
    .cdb_val_in      (cdb_val_in),
    .iss_valid_out   (iss_valid_out),
    .iss_ready_in    (iss_ready_in),
    .iss_op_out      (iss_op_out),
    .iss_dest_out    (iss_dest_out),
    .iss_vj_out      (iss_vj_out),
    .iss_vk_out      (iss_vk_out),
    .count_out       (count_out),
    .almost_full_out (almost_full_out)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input logic [3:0] dest,
                      input logic [3:0] qj,
                      input logic [3:0] qk,
                      input logic [31:0] vj,
                      input logic [31:0] vk);
    disp_valid_in = 1'b1;
    disp_op_in    = 6'd5;
    disp_dest_in  = dest;
    disp_qj_in    = qj;
    disp_qk_in    = qk;
    disp_vj_in    = vj;
    disp_vk_in    = vk;
    step();
    disp_valid_in = 1'b0;
  endtask

  initial begin
    rst_in        = 1'b0;
    rdy_in        = 1'b1;
    flush_in      = 1'b0;
    disp_valid_in = 1'b0;
    disp_op_in    = '0;
    disp_dest_in  = '0;
    disp_vj_in    = '0;
    disp_vk_in    = '0;
    disp_qj_in    = '0;
    disp_qk_in    = '0;
    cdb_valid_in  = '0;
    cdb_tag_in    = '0;
    cdb_val_in    = '0;
    iss_ready_in  = 1'b0;

    step();
    step();
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_dready", 64'(disp_ready_out), 64'd1);
    chk("rst_ivalid", 64'(iss_valid_out), 64'd0);
    chk("rst_afull", 64'(almost_full_out), 64'd0);
    rst_in = 1'b1;
    step();

    // basic dispatch then issue
    disp(4'd3, 4'd0, 4'd0, 32'd10, 32'd20);
    chk("b_ivalid", 64'(iss_valid_out), 64'd1);
    chk("b_op", 64'(iss_op_out), 64'd5);
    chk("b_dest", 64'(iss_dest_out), 64'd3);
    chk("b_vj", 64'(iss_vj_out), 64'd10);
    chk("b_vk", 64'(iss_vk_out), 64'd20);
    chk("b_cnt1", 64'(count_out), 64'd1);
    iss_ready_in = 1'b1;
    step();
    iss_ready_in = 1'b0;
    chk("b_cnt0", 64'(count_out), 64'd0);
    chk("b_ivalid0", 64'(iss_valid_out), 64'd0);

    // wakeup on channel 1
    disp(4'd4, 4'd7, 4'd0, 32'd0, 32'h11);
    chk("w_wait", 64'(iss_valid_out), 64'd0);
    cdb_valid_in = 2'b10;
    cdb_tag_in   = {4'd7, 4'd0};
    cdb_val_in   = {32'hAA, 32'h0};
    #1;
    chk("w_same", 64'(iss_valid_out), 64'd0);
    step();
    cdb_valid_in = 2'b00;
    chk("w_ivalid", 64'(iss_valid_out), 64'd1);
    chk("w_vj", 64'(iss_vj_out), 64'hAA);
    chk("w_vk", 64'(iss_vk_out), 64'h11);
    iss_ready_in = 1'b1;
    step();
    iss_ready_in = 1'b0;
    chk("w_cnt0", 64'(count_out), 64'd0);

    // bypass, both channels match: channel 0 wins
    cdb_valid_in = 2'b11;
    cdb_tag_in   = {4'd9, 4'd9};
    cdb_val_in   = {32'h66, 32'h55};
    disp(4'd5, 4'd0, 4'd9, 32'd1, 32'd0);
    cdb_valid_in = 2'b00;
    chk("p_ivalid", 64'(iss_valid_out), 64'd1);
    chk("p_vk", 64'(iss_vk_out), 64'h55);
    chk("p_dest", 64'(iss_dest_out), 64'd5);
    iss_ready_in = 1'b1;
    step();
    iss_ready_in = 1'b0;

    // fill to full, blocked on tag 2
    for (int i = 0; i < 15; i++)
      disp(4'(i), 4'd2, 4'd0, 32'd0, 32'd0);
    chk("f_cnt15", 64'(count_out), 64'd15);
    chk("f_afull", 64'(almost_full_out), 64'd1);
    chk("f_dready15", 64'(disp_ready_out), 64'd1);
    disp(4'd15, 4'd2, 4'd0, 32'd0, 32'd0);
    chk("f_cnt16", 64'(count_out), 64'd16);
    chk("f_afull16", 64'(almost_full_out), 64'd0);
    chk("f_dready16", 64'(disp_ready_out), 64'd0);
    chk("f_blocked", 64'(iss_valid_out), 64'd0);
    cdb_valid_in = 2'b01;
    cdb_tag_in   = {4'd0, 4'd2};
    cdb_val_in   = {32'h0, 32'h22};
    step();
    cdb_valid_in = 2'b00;
    chk("f_wake", 64'(iss_valid_out), 64'd1);
    chk("f_wvj", 64'(iss_vj_out), 64'h22);
    chk("f_sel0", 64'(iss_dest_out), 64'd0);
    // 17th dispatch with issue in the same cycle
    disp_valid_in = 1'b1;
    disp_dest_in  = 4'hF;
    disp_qj_in    = 4'd0;
    iss_ready_in  = 1'b1;
    #1;
    chk("f_dready_iss", 64'(disp_ready_out), 64'd0);
    step();
    disp_valid_in = 1'b0;
    iss_ready_in  = 1'b0;
    chk("f_cnt_iss", 64'(count_out), 64'd15);
    chk("f_sel1", 64'(iss_dest_out), 64'd1);
    // issue entry 1 while dispatching into freed entry 0
    iss_ready_in = 1'b1;
    disp(4'hE, 4'd0, 4'd0, 32'd7, 32'd8);
    iss_ready_in = 1'b0;
    chk("f_cnt_both", 64'(count_out), 64'd15);
    chk("f_sel_new", 64'(iss_dest_out), 64'hE);
    flush_in = 1'b1;
    #1;
    chk("fl_gate", 64'(iss_valid_out), 64'd0);
    step();
    flush_in = 1'b0;
    chk("fl_cnt", 64'(count_out), 64'd0);
    chk("fl_dready", 64'(disp_ready_out), 64'd1);

    // entries 0 and 5 ready, 1..4 blocked
    disp(4'd1, 4'd0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++)
      disp(4'(i + 2), 4'd3, 4'd0, 32'd0, 32'd0);
    disp(4'd6, 4'd0, 4'd0, 32'd0, 32'd0);
    chk("s_sel0", 64'(iss_dest_out), 64'd1);
    iss_ready_in = 1'b1;
    step();
    chk("s_sel5", 64'(iss_dest_out), 64'd6);
    step();
    iss_ready_in = 1'b0;
    chk("s_cnt4", 64'(count_out), 64'd4);
    chk("s_none", 64'(iss_valid_out), 64'd0);
    for (int i = 0; i < 4; i++)
      disp(4'(i + 8), 4'd3, 4'd0, 32'd0, 32'd0);
    chk("s_cnt8", 64'(count_out), 64'd8);
    // global enable low freezes state
    rdy_in = 1'b0;
    disp_valid_in = 1'b1;
    flush_in = 1'b1;
    step();
    step();
    disp_valid_in = 1'b0;
    flush_in = 1'b0;
    chk("z_cnt", 64'(count_out), 64'd8);
    chk("z_dready", 64'(disp_ready_out), 64'd1);
    rdy_in = 1'b1;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    chk("s_fl_cnt", 64'(count_out), 64'd0);
    chk("s_fl_iv", 64'(iss_valid_out), 64'd0);

    // asynchronous reset between edges
    for (int i = 0; i < 4; i++)
      disp(4'(i + 1), 4'd0, 4'd0, 32'd0, 32'd0);
    chk("r_cnt4", 64'(count_out), 64'd4);
    #2;
    rst_in = 1'b0;
    #1;
    chk("r_cnt0", 64'(count_out), 64'd0);
    chk("r_dready", 64'(disp_ready_out), 64'd1);
    chk("r_ivalid", 64'(iss_valid_out), 64'd0);
    rst_in = 1'b1;
    disp(4'd7, 4'd0, 4'd0, 32'd0, 32'd0);
    chk("r_first", 64'(count_out), 64'd1);
    chk("r_dest", 64'(iss_dest_out), 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rs_station.md
RS_STATION -- requirements
Module: rs_station

Interface
REQ-001 Parameter DEPTH, default 16: entry count; power of two, 4..64.
REQ-002 Parameter CDB_PORTS, default 2: number of broadcast (wakeup) channels, 1..4.
REQ-003 Parameter DATA_W, default 32: operand/value width.
REQ-004 Parameter TAG_W, default 4: ROB tag width; tag 0 = "no dependency".
REQ-005 Parameter OP_W, default 6: opcode field width.
REQ-006 clk_in  input  1  single clock, rising edge.
REQ-007 rst_in  input  1  reset, asynchronous, active-low.
REQ-008 rdy_in  input  1  global enable; 0 freezes all state.
REQ-009 flush_in  input  1  misprediction flush.
REQ-010 disp_valid_in  input  1  dispatch request.
REQ-011 disp_ready_out  output  1  at least one vacant entry.
REQ-012 disp_op_in  input  OP_W  opcode.
REQ-013 disp_dest_in  input  TAG_W  destination ROB tag.
REQ-014 disp_vj_in, disp_vk_in  input  DATA_W each  operand values.
REQ-015 disp_qj_in, disp_qk_in  input  TAG_W each  operand producer tags (0 = value valid).
REQ-016 cdb_valid_in  input  CDB_PORTS  per-channel broadcast valid.
REQ-017 cdb_tag_in  input  CDB_PORTS*TAG_W  packed broadcast tags.
REQ-018 cdb_val_in  input  CDB_PORTS*DATA_W  packed broadcast values.
REQ-019 iss_valid_out  output  1  issue slot holds a ready entry.
REQ-020 iss_ready_in  input  1  functional unit accepts.
REQ-021 iss_op_out, iss_dest_out, iss_vj_out, iss_vk_out  output  OP_W/TAG_W/DATA_W/DATA_W  issued entry fields.
REQ-022 count_out  output  clog2(DEPTH)+1  occupied entries.
REQ-023 almost_full_out  output  1  exactly one vacant entry.

Function
REQ-024 Dispatch handshake: entry written at edge where disp_valid_in & disp_ready_out & rdy_in & !flush_in; written into lowest-index vacant entry.
REQ-025 Wakeup: each cycle, for every busy entry and channel c with cdb_valid_in[c] and Qj (Qk) == cdb_tag_in[c] != 0, set Vj (Vk) = value, Qj (Qk) = 0 at next edge.
REQ-026 Dispatch bypass: dispatched operand whose qj/qk matches a same-cycle valid CDB tag stores the CDB value with Q = 0.
REQ-027 Multiple channels matching one tag: lowest channel index wins.
REQ-028 Entry ready = busy & Qj==0 & Qk==0; ready derived from registered state only (wakeup adds one cycle before issue).
REQ-029 Select: lowest-index ready entry drives iss_*_out combinationally; iss_valid_out = any ready & !flush_in.
REQ-030 Issue handshake: iss_valid_out & iss_ready_in & rdy_in frees selected entry at the edge.
REQ-031 Same-cycle issue and dispatch permitted; freed slot is not reused in that cycle (vacancy computed from pre-edge state).
REQ-032 Full: disp_ready_out=0 when count_out==DEPTH, even if issue fires same cycle.
REQ-033 count_out next = count + dispatch - issue; never exceeds DEPTH, never underflows.
REQ-034 flush_in (with rdy_in) clears all busy bits at next edge; overrides dispatch and issue that cycle; count_out becomes 0.
REQ-035 rdy_in=0: no state changes; outputs still reflect current state.
REQ-036 Issue latency from dispatch with both Q=0: one cycle (entry visible the cycle after write).

Reset
REQ-037 rst_in low asynchronously clears all busy bits and count register; count_out=0, disp_ready_out=1, iss_valid_out=0, almost_full_out=0.
REQ-038 Entry payload registers not reset; outputs gated by busy so payload is don't-care.
REQ-039 Reset asserted mid-dispatch or mid-issue discards the transaction; first dispatch accepted at first edge after deassertion.

Structure
REQ-040 Package rs_pkg holds TAG_NONE constant (0), default widths, and entry struct/typedef (busy, op, dest, vj, vk, qj, qk).
REQ-041 One sub-module rs_prio_enc (parameter N): lowest-set-bit index plus any-set flag; instantiated twice (vacant, ready).

Verification
REQ-042 Reset, dispatch op=5 dest=3 qj=qk=0 vj=10 vk=20 -> next cycle iss_valid_out=1, dest=3, vj=10, vk=20; accept -> count_out 1->0.
REQ-043 Dispatch qj=7; later cdb_valid[1]=1 tag=7 val=0xAA -> iss_valid_out=1 one cycle after broadcast, iss_vj_out=0xAA.
REQ-044 Dispatch qk=9 in same cycle as cdb tag=9 val=0x55 -> entry ready next cycle, iss_vk_out=0x55.
REQ-045 Fill 16 entries (blocked on qj=2): disp_ready_out=0 at count 16, almost_full_out=1 at 15; 17th dispatch not accepted; simultaneous issue does not admit it that cycle.
REQ-046 Entries 0 and 5 ready, entry 0 issued -> entry 5 issued next; flush_in with 8 busy -> count_out=0, iss_valid_out=0 next cycle.
REQ-047 rst_in pulsed low between edges with 4 busy -> immediate count_out=0, disp_ready_out=1.
